// File: rtl/clock_mode_ctrl.sv
// Mode/timekeeping controller: HH:MM:SS registers plus a RUN/SET_HR/SET_MIN/SET_SEC FSM.
// Optional alarm logic is compiled in with `define CLOCK_MODE_CTRL_ALARM_EN.
module clock_mode_ctrl #(
    parameter int HOUR_24 = 1
) (
    input  logic       clk,
    input  logic       rst,
    // tick_sec, btn_mode and btn_inc are single-cycle pulses; each pulse is
    // consumed on the clk edge where it is high and is never held or queued.
    input  logic       tick_sec,
    input  logic       btn_mode,
    input  logic       btn_inc,
`ifdef CLOCK_MODE_CTRL_ALARM_EN
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_on,
    output logic       alarm,
`endif
    output logic [1:0] state,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       blink,
    output logic       div_clr
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } mode_t;

    localparam logic [4:0] HR_MAX = (HOUR_24 != 0) ? 5'd23 : 5'd12;
    localparam logic [4:0] HR_MIN = (HOUR_24 != 0) ? 5'd0  : 5'd1;
    localparam logic [4:0] HR_RST = (HOUR_24 != 0) ? 5'd0  : 5'd12;

    mode_t      state_q, state_d;
    logic [4:0] hours_d;
    logic [5:0] minutes_d, seconds_d;
    logic       blink_d, div_clr_d;

    function automatic logic [4:0] hr_inc(input logic [4:0] h);
        return (h == HR_MAX) ? HR_MIN : h + 5'd1;
    endfunction

    function automatic logic [5:0] ms_inc(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hours_d   = hours;
        minutes_d = minutes;
        seconds_d = seconds;
        blink_d   = blink;
        div_clr_d = 1'b0;

        // A mode change always restarts blinking with the field visible.
        if (btn_mode) begin
            blink_d = 1'b0;
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                SET_MIN: state_d = SET_SEC;
                default: begin
                    state_d   = RUN;
                    div_clr_d = 1'b1;
                end
            endcase
        end

        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                // The tick still counts when btn_mode arrives in the same cycle.
                if (tick_sec) begin
                    seconds_d = ms_inc(seconds);
                    if (seconds == 6'd59) begin
                        minutes_d = ms_inc(minutes);
                        if (minutes == 6'd59) begin
                            hours_d = hr_inc(hours);
                        end
                    end
                end
            end
            SET_HR:  if (!btn_mode && btn_inc) hours_d   = hr_inc(hours);
            SET_MIN: if (!btn_mode && btn_inc) minutes_d = ms_inc(minutes);
            default: if (!btn_mode && btn_inc) seconds_d = ms_inc(seconds);
        endcase

        if (state_q != RUN && !btn_mode && tick_sec) begin
            blink_d = ~blink;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hours   <= HR_RST;
            minutes <= 6'd0;
            seconds <= 6'd0;
            blink   <= 1'b0;
            div_clr <= 1'b0;
        end else begin
            hours   <= hours_d;
            minutes <= minutes_d;
            seconds <= seconds_d;
            blink   <= blink_d;
            div_clr <= div_clr_d;
        end
    end

    assign state = state_q;

`ifdef CLOCK_MODE_CTRL_ALARM_EN
    logic [5:0] alarm_cnt, alarm_cnt_d;
    logic       alarm_d;

    // Match is taken against the time that the current tick is producing.
    always_comb begin
        alarm_d     = alarm;
        alarm_cnt_d = alarm_cnt;
        if (btn_mode || !alarm_on || (state_q == RUN && btn_inc)) begin
            alarm_d = 1'b0;
        end else if (alarm) begin
            if (tick_sec) begin
                alarm_cnt_d = alarm_cnt + 6'd1;
                if (alarm_cnt == 6'd59) begin
                    alarm_d = 1'b0;
                end
            end
        end else if (state_q == RUN && tick_sec && hours_d == alarm_hr &&
                     minutes_d == alarm_min && seconds_d == 6'd0) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm     <= 1'b0;
            alarm_cnt <= 6'd0;
        end else begin
            alarm     <= alarm_d;
            alarm_cnt <= alarm_cnt_d;
        end
    end
`endif

endmodule
